// File: rtl/hls_deadlock_report_ctrl.sv
// Deadlock report controller: confirms per-channel block flags that stay high
// for PERSIST consecutive cycles, timestamps each confirmation, and offers the
// confirmed channels one at a time over a valid/ready report port (round-robin).
module hls_deadlock_report_ctrl #(
  parameter int PERSIST = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  mon_block,
  input  logic        clear,
  output logic        rpt_valid,
  input  logic        rpt_ready,
  output logic [1:0]  rpt_idx,
  output logic [15:0] rpt_time,
  output logic [3:0]  confirmed,
  output logic        deadlock
);

  localparam logic [15:0] CNT_MAX = 16'(PERSIST - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t      state_q, state_d;
  logic [15:0] ts_q, ts_d;
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];
  logic [15:0] stamp_q [4];
  logic [15:0] stamp_d [4];
  logic [3:0]  confirmed_q, confirmed_d;
  logic [3:0]  pending_q, pending_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] time_q, time_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [3:0]  confirm_set;
  logic [3:0]  pending_clr;
  logic [1:0]  pick;

  // Round-robin pick: first requester found scanning upward from last+1.
  // Scanning offsets from 4 down to 1 lets the smallest offset win.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] c;
    rr_pick = last;
    for (int off = 4; off >= 1; off--) begin
      c = last + 2'(off);
      if (req[c]) rr_pick = c;
    end
  endfunction

  // Next-state logic: timestamp, persistence counters, confirmation, report FSM.
  always_comb begin
    ts_d         = ts_q + 16'd1;
    cnt_d        = cnt_q;
    stamp_d      = stamp_q;
    state_d      = state_q;
    idx_d        = idx_q;
    time_d       = time_q;
    last_grant_d = last_grant_q;
    confirm_set  = '0;
    pending_clr  = '0;
    pick         = rr_pick(pending_q, last_grant_q);

    for (int i = 0; i < 4; i++) begin
      if (!mon_block[i]) begin
        cnt_d[i] = '0;
      end else if (!confirmed_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          // Confirmed channels stop counting, so the counter parks at zero.
          cnt_d[i]       = '0;
          confirm_set[i] = 1'b1;
          stamp_d[i]     = ts_q;
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          idx_d   = pick;
          time_d  = stamp_q[pick];
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (rpt_ready) begin
          pending_clr[idx_q] = 1'b1;
          last_grant_d       = idx_q;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A same-cycle confirmation can never hit the accepted channel, which is
    // already confirmed, so clearing before setting loses nothing.
    confirmed_d = confirmed_q | confirm_set;
    pending_d   = (pending_q & ~pending_clr) | confirm_set;

    // clear wipes detection state and drops any offer; last_grant survives.
    if (clear) begin
      for (int i = 0; i < 4; i++) begin
        cnt_d[i]   = '0;
        stamp_d[i] = '0;
      end
      confirmed_d  = '0;
      pending_d    = '0;
      state_d      = IDLE;
      idx_d        = idx_q;
      time_d       = time_q;
      last_grant_d = last_grant_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q         <= '0;
      confirmed_q  <= '0;
      pending_q    <= '0;
      state_q      <= IDLE;
      idx_q        <= '0;
      time_q       <= '0;
      last_grant_q <= 2'd3;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]   <= '0;
        stamp_q[i] <= '0;
      end
    end else begin
      ts_q         <= ts_d;
      confirmed_q  <= confirmed_d;
      pending_q    <= pending_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      time_q       <= time_d;
      last_grant_q <= last_grant_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]   <= cnt_d[i];
        stamp_q[i] <= stamp_d[i];
      end
    end
  end

  assign rpt_valid = (state_q == OFFER);
  assign rpt_idx   = idx_q;
  assign rpt_time  = time_q;
  assign confirmed = confirmed_q;
  assign deadlock  = |confirmed_q;

endmodule
